// File: rtl/unstriping_pkg.sv
// Definitions shared by the unstriping stage and its lane FIFOs.
// The data width default matches the upstream striping stage.
package unstriping_pkg;

    localparam int DATA_WIDTH = 32;

    // Selects which lane supplies the next word of the recombined stream.
    typedef enum logic {
        EXPECT_L0 = 1'b0,
        EXPECT_L1 = 1'b1
    } sel_t;

endpackage

// File: rtl/unstriping_lane_fifo.sv
// Per-lane skew buffer with a combinational head read.
// A push into a full FIFO is accepted only when a pop frees a slot in the same edge.
module lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_2f) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/unstriping.sv
// Recombines two striped lanes into one ordered word stream, lane 0 first.
// Each lane has its own FIFO so the lanes may arrive skewed relative to each other.
module unstriping
    import unstriping_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             valid_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             overflow_err
);

    sel_t             sel;
    sel_t             sel_next;
    logic             pop_0;
    logic             pop_1;
    logic [WIDTH-1:0] rdata_0;
    logic [WIDTH-1:0] rdata_1;
    logic             empty_0;
    logic             empty_1;
    logic             full_0;
    logic             full_1;
    logic             drop_word;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid_0),
        .wdata  (lane_0),
        .pop    (pop_0),
        .rdata  (rdata_0),
        .empty  (empty_0),
        .full   (full_0)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid_1),
        .wdata  (lane_1),
        .pop    (pop_1),
        .rdata  (rdata_1),
        .empty  (empty_1),
        .full   (full_1)
    );

    // Only the expected lane may be popped; the other lane waits even if it has data.
    always_comb begin
        sel_next = sel;
        pop_0    = 1'b0;
        pop_1    = 1'b0;
        case (sel)
            EXPECT_L0: begin
                if (!empty_0) begin
                    pop_0    = 1'b1;
                    sel_next = EXPECT_L1;
                end
            end
            EXPECT_L1: begin
                if (!empty_1) begin
                    pop_1    = 1'b1;
                    sel_next = EXPECT_L0;
                end
            end
            default: sel_next = EXPECT_L0;
        endcase
    end

    assign drop_word = (valid_0 && full_0 && !pop_0) ||
                       (valid_1 && full_1 && !pop_1);

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel          <= EXPECT_L0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            sel       <= sel_next;
            valid_out <= pop_0 || pop_1;
            if (pop_0) begin
                data_out <= rdata_0;
            end else if (pop_1) begin
                data_out <= rdata_1;
            end
            if (drop_word) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unstriping.sv
// Directed self-checking bench for unstriping: reset, alignment, skew,
// overflow, full-FIFO push/pop and mid-stream reset.
module tb_unstriping;

    localparam int W = 32;

    logic         clk_2f = 1'b0;
    logic         reset  = 1'b1;
    logic [W-1:0] lane_0 = '0;
    logic         valid_0 = 1'b0;
    logic [W-1:0] lane_1 = '0;
    logic         valid_1 = 1'b0;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         overflow_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] out_q[$];
    logic [W-1:0] exp_q[$];

    unstriping #(.WIDTH(W), .DEPTH(4)) dut (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .lane_0       (lane_0),
        .valid_0      (valid_0),
        .lane_1       (lane_1),
        .valid_1      (valid_1),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .overflow_err (overflow_err)
    );

    always #5 clk_2f = ~clk_2f;

    // Drives one cycle of inputs, then samples just after the rising edge.
    task automatic applyStimulus(input logic v0, input logic [W-1:0] d0,
                                 input logic v1, input logic [W-1:0] d1);
        @(negedge clk_2f);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        @(posedge clk_2f);
        #1;
        if (valid_out === 1'b1) out_q.push_back(data_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0);
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid,
                               input logic [W-1:0] exp_data);
        checks++;
        assert (valid_out === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s valid_out: got %b expected %b", tag, valid_out, exp_valid);
        end
        checks++;
        assert (data_out === exp_data) else begin
            errors++;
            $error("[TB] FAIL %s data_out: got %h expected %h", tag, data_out, exp_data);
        end
    endtask

    task automatic checkFlag(input string tag, input logic exp_ovf);
        checks++;
        assert (overflow_err === exp_ovf) else begin
            errors++;
            $error("[TB] FAIL %s overflow_err: got %b expected %b", tag, overflow_err, exp_ovf);
        end
    endtask

    task automatic checkStream(input string tag);
        checks++;
        assert (out_q.size() == exp_q.size()) else begin
            errors++;
            $error("[TB] FAIL %s count: got %0d expected %0d", tag, out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_q.size()) begin
                checks++;
                assert (out_q[i] === exp_q[i]) else begin
                    errors++;
                    $error("[TB] FAIL %s word %0d: got %h expected %h", tag, i, out_q[i], exp_q[i]);
                end
            end
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        $display("[TB] start");

        // Reset held two cycles while both lanes are valid.
        reset = 1'b1;
        applyStimulus(1'b1, 32'h55, 1'b1, 32'h66);
        checkOutput("rst0", 1'b0, 32'h0);
        checkFlag("rst0", 1'b0);
        applyStimulus(1'b1, 32'h57, 1'b1, 32'h67);
        checkOutput("rst1", 1'b0, 32'h0);
        checkFlag("rst1", 1'b0);
        reset = 1'b0;
        idle(3);
        checkOutput("rst_empty", 1'b0, 32'h0);
        checkFlag("rst_empty", 1'b0);

        // Aligned lanes: output starts two edges after the first input.
        applyStimulus(1'b1, 32'hA0, 1'b1, 32'hA1);
        checkOutput("align_e1", 1'b0, 32'h0);
        applyStimulus(1'b1, 32'hA2, 1'b1, 32'hA3);
        checkOutput("align_e2", 1'b1, 32'hA0);
        idle(1);
        checkOutput("align_e3", 1'b1, 32'hA1);
        idle(1);
        checkOutput("align_e4", 1'b1, 32'hA2);
        idle(1);
        checkOutput("align_e5", 1'b1, 32'hA3);
        idle(1);
        checkOutput("align_hold", 1'b0, 32'hA3);
        out_q.delete();

        // Skew: lane 1 arrives three cycles ahead of lane 0 and must wait.
        applyStimulus(1'b0, '0, 1'b1, 32'hB1);
        checkOutput("skew_e1", 1'b0, 32'hA3);
        idle(2);
        checkOutput("skew_e3", 1'b0, 32'hA3);
        applyStimulus(1'b1, 32'hB0, 1'b0, '0);
        checkOutput("skew_e4", 1'b0, 32'hA3);
        idle(1);
        checkOutput("skew_e5", 1'b1, 32'hB0);
        idle(1);
        checkOutput("skew_e6", 1'b1, 32'hB1);
        idle(1);
        checkOutput("skew_e7", 1'b0, 32'hB1);
        out_q.delete();

        // Overflow: C0 is popped, C1..C4 fill the FIFO, C5 is dropped.
        applyStimulus(1'b1, 32'hC0, 1'b0, '0);
        checkOutput("ovf_e1", 1'b0, 32'hB1);
        applyStimulus(1'b1, 32'hC1, 1'b0, '0);
        checkOutput("ovf_e2", 1'b1, 32'hC0);
        applyStimulus(1'b1, 32'hC2, 1'b0, '0);
        applyStimulus(1'b1, 32'hC3, 1'b0, '0);
        applyStimulus(1'b1, 32'hC4, 1'b0, '0);
        checkOutput("ovf_stall", 1'b0, 32'hC0);
        checkFlag("ovf_full", 1'b0);
        applyStimulus(1'b1, 32'hC5, 1'b0, '0);
        checkFlag("ovf_drop", 1'b1);
        out_q.delete();
        applyStimulus(1'b0, '0, 1'b1, 32'hF1);
        applyStimulus(1'b0, '0, 1'b1, 32'hF3);
        applyStimulus(1'b0, '0, 1'b1, 32'hF5);
        applyStimulus(1'b0, '0, 1'b1, 32'hF7);
        applyStimulus(1'b0, '0, 1'b1, 32'hF9);
        idle(12);
        checkFlag("ovf_sticky", 1'b1);
        exp_q = '{32'hF1, 32'hC1, 32'hF3, 32'hC2, 32'hF5,
                  32'hC3, 32'hF7, 32'hC4, 32'hF9};
        checkStream("ovf_stream");

        // Full FIFO pushed and popped on the same edge: no overflow.
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0);
        reset = 1'b0;
        checkFlag("pp_reset", 1'b0);
        out_q.delete();
        applyStimulus(1'b1, 32'h10, 1'b0, '0);
        applyStimulus(1'b1, 32'h12, 1'b0, '0);
        applyStimulus(1'b1, 32'h14, 1'b0, '0);
        applyStimulus(1'b1, 32'h16, 1'b0, '0);
        applyStimulus(1'b1, 32'h18, 1'b0, '0);
        checkFlag("pp_full", 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'h11);
        applyStimulus(1'b0, '0, 1'b1, 32'h13);
        applyStimulus(1'b1, 32'h1A, 1'b1, 32'h15);
        checkOutput("pp_edge", 1'b1, 32'h12);
        checkFlag("pp_edge", 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'h17);
        applyStimulus(1'b0, '0, 1'b1, 32'h19);
        applyStimulus(1'b0, '0, 1'b1, 32'h1B);
        idle(8);
        checkFlag("pp_end", 1'b0);
        exp_q = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15,
                  32'h16, 32'h17, 32'h18, 32'h19, 32'h1A, 32'h1B};
        checkStream("pp_stream");

        // Mid-stream reset with three words buffered in lane 0.
        applyStimulus(1'b1, 32'h30, 1'b0, '0);
        applyStimulus(1'b1, 32'h32, 1'b0, '0);
        applyStimulus(1'b1, 32'h34, 1'b0, '0);
        applyStimulus(1'b1, 32'h36, 1'b0, '0);
        checkOutput("mid_buffered", 1'b0, 32'h30);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h38, 1'b1, 32'h39);
        checkOutput("mid_reset", 1'b0, 32'h0);
        checkFlag("mid_reset", 1'b0);
        reset = 1'b0;
        out_q.delete();
        applyStimulus(1'b1, 32'hD0, 1'b1, 32'hD1);
        checkOutput("mid_e1", 1'b0, 32'h0);
        idle(1);
        checkOutput("mid_e2", 1'b1, 32'hD0);
        idle(1);
        checkOutput("mid_e3", 1'b1, 32'hD1);
        idle(1);
        checkOutput("mid_e4", 1'b0, 32'hD1);
        idle(4);
        exp_q = '{32'hD0, 32'hD1};
        checkStream("mid_stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
